pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the five-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Generates every stage's Ld and Clr, plus PCWrite, from hazard inputs:
  - load-use stalls;
  - multi-cycle mult/div (HI/LO) busy stalls;
  - taken-branch/jump flushes resolved in MEM.
- Also keeps saturating stall and flush statistics counters.

Parameters:
- MUL_LAT, 4, cycles the HI/LO unit is busy after a mult issues; must be ≥1.
- DIV_LAT, 32, cycles the HI/LO unit is busy after a div issues; must be ≥1.
- CNT_W, 6, width of the busy down-counter; must satisfy 2^CNT_W > max(MUL_LAT, DIV_LAT).

Ports:
- Clk  in  1  clock.
- Rst  in  1  reset, asynchronous, active-high.
- ID_Rs  in  5  rs field of the instruction in ID.
- ID_Rt  in  5  rt field of the instruction in ID.
- ID_UsesRt  in  1  the ID instruction reads rt as a source.
- ID_ReadsHiLo  in  1  the ID instruction is mfhi or mflo.
- ID_MdOp  in  1  the ID instruction is mult, multu, div or divu.
- EX_MemRead  in  1  the EX instruction is a load.
- EX_RegDstData  in  5  destination register of the EX instruction.
- EX_MdStart  in  1  a mult/div is in EX this cycle.
- EX_MdIsDiv  in  1  qualifies EX_MdStart: 1 = div, 0 = mult.
- MEM_Branch  in  1  branch in MEM.
- MEM_Zero  in  1  branch condition result in MEM.
- MEM_Jump  in  2  jump type in MEM; nonzero = jump.
- PCWrite  out  1  PC load enable.
- IF_ID_Ld, IF_ID_Clr  out  1 each.
- ID_EX_Ld, ID_EX_Clr  out  1 each.
- EX_MEM_Ld, EX_MEM_Clr  out  1 each.
- MEM_WB_Ld, MEM_WB_Clr  out  1 each.
- MdBusy  out  1  HI/LO unit busy (state == MD_BUSY).
- StallCnt  out  16  saturating count of stall cycles.
- FlushCnt  out  16  saturating count of redirects.

Behaviour:
- Reset (Rst high, asynchronous):
  - state = RUN, busy counter = 0, StallCnt = 0, FlushCnt = 0.
  - While Rst is high: all *_Clr = 1, all *_Ld = 0, PCWrite = 0, MdBusy = 0.
  - Reset mid-mult/div abandons the operation immediately.
- Output timing: control outputs are combinational from the registered state and current inputs; zero-cycle latency. Counters and state update on the posedge of Clk.
- Condition definitions:
  - redirect = (MEM_Branch & MEM_Zero) | (MEM_Jump != 0).
  - loaduse = EX_MemRead & (EX_RegDstData != 0) & (EX_RegDstData == ID_Rs | (ID_UsesRt & EX_RegDstData == ID_Rt)).
  - mdstall = (state == MD_BUSY) & (ID_ReadsHiLo | ID_MdOp).
  - stall = (loaduse | mdstall) & ~redirect.
- Priority: redirect > stall > normal.
- Normal:
  - every Ld = 1, every Clr = 0, PCWrite = 1.
- Stall:
  - PCWrite = 0, IF_ID_Ld = 0 (IF and ID hold).
  - ID_EX_Clr = 1 (bubble inserted).
  - EX_MEM_Ld = 1, MEM_WB_Ld = 1; all other Clr = 0.
  - StallCnt increments.
- Redirect:
  - IF_ID_Clr = 1, ID_EX_Clr = 1, EX_MEM_Clr = 1.
  - PCWrite = 1 (PC takes the target), MEM_WB_Ld = 1.
  - FlushCnt increments.
  - A coincident load-use or mdstall is discarded because the younger instruction is squashed.
- FSM, RUN → MD_BUSY:
  - Taken on EX_MdStart & ~redirect.
  - Counter loads (EX_MdIsDiv ? DIV_LAT : MUL_LAT) − 1.
  - EX_MdStart coincident with redirect is squashed: no transition.
- FSM, MD_BUSY:
  - If counter == 0, go to RUN; otherwise decrement.
  - MdBusy is therefore high for exactly LAT cycles, starting the cycle after EX_MdStart.
  - A redirect during MD_BUSY does not cancel the counter: the mult/div is older than the branch.
- Illegal input: EX_MdStart in MD_BUSY cannot occur because ID_MdOp stalls. It is ignored, and the bench asserts it never occurs.
- Counter saturation: StallCnt and FlushCnt saturate at 16'hFFFF with no wrap.
- Register 0: a load to $0 never causes a stall.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - the state enum (RUN = 0, MD_BUSY = 1);
  - the stage-control struct {Ld, Clr};
  - the JUMP_NONE = 2'b00 constant.
- One natural sub-module: sat_counter16, a 16-bit saturating incrementer with asynchronous reset. It is instantiated twice, for StallCnt and FlushCnt.

Test Plan:
1. Load-use: EX_MemRead=1, EX_RegDstData=8, ID_Rs=8 → exactly one cycle of PCWrite=0, IF_ID_Ld=0, ID_EX_Clr=1. Next cycle (EX_MemRead=0) all Ld=1. StallCnt=1.
2. Load to $0: EX_RegDstData=0, ID_Rs=0 → no stall. Also ID_UsesRt=0 with ID_Rt=8 matching → no stall.
3. Div then mfhi: EX_MdStart=1, EX_MdIsDiv=1 → MdBusy high for 32 cycles. ID_ReadsHiLo=1 held throughout → 32 stall cycles, then release. StallCnt=32. Repeat with mult → 4 cycles.
4. Redirect with load-use: MEM_Branch=1, MEM_Zero=1 in the same cycle as load-use → IF_ID_Clr = ID_EX_Clr = EX_MEM_Clr = 1, PCWrite=1. FlushCnt=1, StallCnt unchanged.
5. Redirect vs mult: redirect coincident with EX_MdStart → MdBusy stays 0. Redirect during MD_BUSY (MEM_Jump=2'b01) → counter continues to 0.
6. Async reset: Rst asserted mid-MD_BUSY between clock edges → immediately all Clr=1, all Ld=0, PCWrite=0, MdBusy=0, counters=0. After release → state RUN.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: sequencer state,
// per-stage load/clear pair and the "no jump" encoding.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  typedef struct packed {
    logic ld;
    logic clr;
  } stage_ctrl_t;

  localparam logic [1:0] JUMP_NONE = 2'b00;

  localparam stage_ctrl_t STAGE_PASS  = '{ld: 1'b1, clr: 1'b0};
  localparam stage_ctrl_t STAGE_RESET = '{ld: 1'b0, clr: 1'b1};

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter16 (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        inc,
  output logic [15:0] count
);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)
      count <= '0;
    else if (inc && (count != 16'hFFFF))
      count <= count + 16'd1;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline register sequencer: load-use and HI/LO busy stalls, MEM-stage
// redirect flushes, and stall/flush statistics.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_UsesRt,
  input  logic        ID_ReadsHiLo,
  input  logic        ID_MdOp,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_RegDstData,
  input  logic        EX_MdStart,
  input  logic        EX_MdIsDiv,
  input  logic        MEM_Branch,
  input  logic        MEM_Zero,
  input  logic [1:0]  MEM_Jump,
  output logic        PCWrite,
  output logic        IF_ID_Ld,
  output logic        IF_ID_Clr,
  output logic        ID_EX_Ld,
  output logic        ID_EX_Clr,
  output logic        EX_MEM_Ld,
  output logic        EX_MEM_Clr,
  output logic        MEM_WB_Ld,
  output logic        MEM_WB_Clr,
  output logic        MdBusy,
  output logic [15:0] StallCnt,
  output logic [15:0] FlushCnt
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  md_state_t        state;
  logic [CNT_W-1:0] busy_cnt;
  logic             redirect;
  logic             load_use;
  logic             md_stall;
  logic             stall;
  logic             pc_write;
  stage_ctrl_t      if_id;
  stage_ctrl_t      id_ex;
  stage_ctrl_t      ex_mem;
  stage_ctrl_t      mem_wb;

  assign redirect = (MEM_Branch & MEM_Zero) | (MEM_Jump != JUMP_NONE);
  assign load_use = EX_MemRead && (EX_RegDstData != 5'd0) &&
                    ((EX_RegDstData == ID_Rs) ||
                     (ID_UsesRt && (EX_RegDstData == ID_Rt)));
  assign md_stall = (state == MD_BUSY) && (ID_ReadsHiLo || ID_MdOp);
  // A redirect squashes the younger instruction, so its hazard no longer matters.
  assign stall    = (load_use || md_stall) && !redirect;

  always_comb begin
    pc_write = 1'b1;
    if_id    = STAGE_PASS;
    id_ex    = STAGE_PASS;
    ex_mem   = STAGE_PASS;
    mem_wb   = STAGE_PASS;
    if (Rst) begin
      pc_write = 1'b0;
      if_id    = STAGE_RESET;
      id_ex    = STAGE_RESET;
      ex_mem   = STAGE_RESET;
      mem_wb   = STAGE_RESET;
    end else if (redirect) begin
      if_id.clr  = 1'b1;
      id_ex.clr  = 1'b1;
      ex_mem.clr = 1'b1;
    end else if (stall) begin
      pc_write  = 1'b0;
      if_id.ld  = 1'b0;
      id_ex.clr = 1'b1;
    end
  end

  assign PCWrite    = pc_write;
  assign IF_ID_Ld   = if_id.ld;
  assign IF_ID_Clr  = if_id.clr;
  assign ID_EX_Ld   = id_ex.ld;
  assign ID_EX_Clr  = id_ex.clr;
  assign EX_MEM_Ld  = ex_mem.ld;
  assign EX_MEM_Clr = ex_mem.clr;
  assign MEM_WB_Ld  = mem_wb.ld;
  assign MEM_WB_Clr = mem_wb.clr;
  assign MdBusy     = (state == MD_BUSY);

  // Busy countdown keeps running through redirects: the mult/div is older than the branch.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state    <= RUN;
      busy_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (EX_MdStart && !redirect) begin
            state    <= MD_BUSY;
            busy_cnt <= EX_MdIsDiv ? DIV_LOAD : MUL_LOAD;
          end
        end
        MD_BUSY: begin
          if (busy_cnt == '0)
            state <= RUN;
          else
            busy_cnt <= busy_cnt - 1'b1;
        end
        default: state <= RUN;
      endcase
    end
  end

  sat_counter16 u_stall_cnt (
    .Clk   (Clk),
    .Rst   (Rst),
    .inc   (stall),
    .count (StallCnt)
  );

  sat_counter16 u_flush_cnt (
    .Clk   (Clk),
    .Rst   (Rst),
    .inc   (redirect),
    .count (FlushCnt)
  );

endmodule
